// File: rtl/prog_mem_dual_loader_pkg.sv
// Shared widths and loader state encodings for the dual-read program memory.
// Also used by the fetch stage so that both sides agree on widths.
package prog_mem_dual_loader_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 15;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_t;

endpackage

// File: rtl/prog_mem_dual_loader_if.sv
// Read ports plus the byte-stream loader bundle of the program memory.
// Master drives addresses and load stream; slave is the memory.
interface prog_mem_dual_loader_if #(
    parameter int DATA_W = prog_mem_dual_loader_pkg::DATA_W_DEF,
    parameter int ADDR_W = prog_mem_dual_loader_pkg::ADDR_W_DEF
);
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic              rd_en;
    logic [DATA_W-1:0] q_a;
    logic [DATA_W-1:0] q_b;
    logic              ld_start;
    logic [ADDR_W-1:0] ld_base;
    logic [ADDR_W:0]   ld_len;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_busy;
    logic              ld_done;
    logic [DATA_W-1:0] ld_sum;

    modport master (
        output addr_a, addr_b, rd_en, ld_start, ld_base, ld_len, ld_valid, ld_data,
        input  q_a, q_b, ld_ready, ld_busy, ld_done, ld_sum
    );

    modport slave (
        input  addr_a, addr_b, rd_en, ld_start, ld_base, ld_len, ld_valid, ld_data,
        output q_a, q_b, ld_ready, ld_busy, ld_done, ld_sum
    );

endinterface

// File: rtl/prog_mem_loader_fsm.sv
// Loader FSM: streams ld_len words into consecutive (wrapping) addresses, keeps a checksum.
// Latency: write issued in the same cycle a word is accepted; ld_done one cycle after last word.
// Backpressure: ld_ready is high only in LOAD; ld_valid low simply stalls the load.
module prog_mem_loader_fsm
    import prog_mem_dual_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic [DATA_W-1:0] ld_sum,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);

    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    ld_state_t         state;
    ld_state_t         state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   cnt;
    logic              accept;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= LD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        ld_done   = 1'b0;
        case (state)
            LD_IDLE: begin
                if (ld_start) begin
                    state_nxt = (ld_len == '0) ? LD_DONE : LD_LOAD;
                end
            end
            LD_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid && (cnt == CNT_ONE)) begin
                    state_nxt = LD_DONE;
                end
            end
            LD_DONE: begin
                ld_done   = 1'b1;
                state_nxt = LD_IDLE;
            end
            default: state_nxt = LD_IDLE;
        endcase
    end

    assign accept  = ld_ready && ld_valid;
    assign ld_busy = (state != LD_IDLE);

    always_ff @(posedge clk) begin
        if (clr) begin
            ptr    <= '0;
            cnt    <= '0;
            ld_sum <= '0;
        end else if ((state == LD_IDLE) && ld_start) begin
            ptr    <= ld_base;
            cnt    <= ld_len;
            ld_sum <= '0;
        end else if (accept) begin
            ptr    <= ptr + PTR_ONE;
            cnt    <= cnt - CNT_ONE;
            ld_sum <= ld_sum + ld_data;
        end
    end

    // A word presented together with clr must not land in the array.
    assign we    = accept && !clr;
    assign waddr = ptr;
    assign wdata = ld_data;

endmodule

// File: rtl/prog_mem_dual_loader.sv
// Dual-read program memory with a run-time byte-stream loader.
// Latency: 1 cycle address to q_a/q_b; reads hold while the loader is busy.
// Backpressure: load stream uses valid/ready; read ports are never stalled except by a load.
module prog_mem_dual_loader
    import prog_mem_dual_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  clr,
    prog_mem_dual_loader_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    prog_mem_loader_fsm #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fsm (
        .clk      (clk),
        .clr      (clr),
        .ld_start (bus.ld_start),
        .ld_base  (bus.ld_base),
        .ld_len   (bus.ld_len),
        .ld_valid (bus.ld_valid),
        .ld_data  (bus.ld_data),
        .ld_ready (bus.ld_ready),
        .ld_busy  (bus.ld_busy),
        .ld_done  (bus.ld_done),
        .ld_sum   (bus.ld_sum),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata)
    );

    // Array contents survive clr; only the loader may change them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            bus.q_a <= '0;
            bus.q_b <= '0;
        end else if (bus.rd_en && !bus.ld_busy) begin
            bus.q_a <= mem[bus.addr_a];
            bus.q_b <= mem[bus.addr_b];
        end
    end

endmodule

// File: tb/tb_prog_mem_dual_loader.sv
// Directed bench: stimulus pushes expected read data and load checksums into queues,
// a negedge monitor pops and compares whenever the DUT presents read data or ld_done.
module tb_prog_mem_dual_loader;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    prog_mem_dual_loader_if #(.DATA_W(8), .ADDR_W(15)) bus ();

    prog_mem_dual_loader #(.DATA_W(8), .ADDR_W(15)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] rd_q [$];
    logic [7:0]  done_q [$];
    logic [7:0]  exp_a = 8'h00;
    logic [7:0]  exp_b = 8'h00;
    logic        rd_seen = 1'b0;
    logic [15:0] e_rd;
    logic [7:0]  e_sum;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every clock step goes through here so each sampled rd_en has an expectation queued.
    task automatic tick();
        if (bus.rd_en) rd_q.push_back({exp_a, exp_b});
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) rd_seen <= bus.rd_en;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_unexpected: got q_a=0x%0h q_b=0x%0h, expected no read", bus.q_a, bus.q_b);
            end else begin
                e_rd = rd_q.pop_front();
                chk("q_a", {24'h0, bus.q_a}, {24'h0, e_rd[15:8]});
                chk("q_b", {24'h0, bus.q_b}, {24'h0, e_rd[7:0]});
            end
        end
        if (bus.ld_done) begin
            if (done_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL ld_done_unexpected: got ld_done=1, expected 0");
            end else begin
                e_sum = done_q.pop_front();
                chk("ld_sum_at_done", {24'h0, bus.ld_sum}, {24'h0, e_sum});
            end
        end
    end

    task automatic read2(input logic [14:0] a, input logic [14:0] b,
                         input logic [7:0] ea, input logic [7:0] eb);
        bus.addr_a = a;
        bus.addr_b = b;
        exp_a      = ea;
        exp_b      = eb;
        bus.rd_en  = 1'b1;
        tick();
        bus.rd_en  = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.ld_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.ld_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL ready_timeout: got ld_ready=0, expected 1 within 20 cycles");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.ld_busy && n < 40) begin
            tick();
            n++;
        end
        if (bus.ld_busy) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle_timeout: got ld_busy=1, expected 0 within 40 cycles");
        end
    endtask

    task automatic load(input logic [14:0] base, input logic [15:0] len,
                        input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input logic [7:0] w3,
                        input int gap, input bit freeze, input bit midstart,
                        input logic [7:0] esum);
        logic [7:0] w [4];
        w = '{w0, w1, w2, w3};
        done_q.push_back(esum);
        bus.ld_base  = base;
        bus.ld_len   = len;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        if (freeze) bus.rd_en = 1'b1;
        for (int i = 0; i < int'(len); i++) begin
            for (int g = 0; g < gap; g++) begin
                bus.ld_valid = 1'b0;
                tick();
            end
            if (midstart && i == 0) begin
                bus.ld_start = 1'b1;
                bus.ld_base  = 15'h0040;
                bus.ld_len   = 16'd1;
            end
            bus.ld_valid = 1'b1;
            bus.ld_data  = w[i];
            wait_ready();
            tick();
            bus.ld_start = 1'b0;
        end
        bus.ld_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr          = 1'b1;
        bus.addr_a   = '0;
        bus.addr_b   = '0;
        bus.rd_en    = 1'b0;
        bus.ld_start = 1'b0;
        bus.ld_base  = '0;
        bus.ld_len   = '0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        tick();
        tick();
        chk("rst_q_a",      {24'h0, bus.q_a},    32'h0);
        chk("rst_q_b",      {24'h0, bus.q_b},    32'h0);
        chk("rst_ld_ready", {31'h0, bus.ld_ready}, 32'h0);
        chk("rst_ld_done",  {31'h0, bus.ld_done},  32'h0);
        chk("rst_ld_busy",  {31'h0, bus.ld_busy},  32'h0);
        chk("rst_ld_sum",   {24'h0, bus.ld_sum}, 32'h0);
        clr = 1'b0;

        // Known image in the regions the tests touch.
        load(15'h0000, 16'd4, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 0, 1'b0, 1'b0, 8'h86);
        load(15'h0020, 16'd4, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 0, 1'b0, 1'b0, 8'h06);

        // Reads, then clr forces q to zero and it stays there.
        read2(15'h0000, 15'h0001, 8'hA0, 8'hA1);
        clr       = 1'b1;
        exp_a     = 8'h00;
        exp_b     = 8'h00;
        bus.rd_en = 1'b1;
        tick();
        tick();
        bus.rd_en = 1'b0;
        clr       = 1'b0;
        tick();
        chk("post_clr_q_a", {24'h0, bus.q_a}, 32'h0);
        chk("post_clr_q_b", {24'h0, bus.q_b}, 32'h0);
        read2(15'h0000, 15'h0001, 8'hA0, 8'hA1);

        // Three words with gaps in ld_valid.
        load(15'h0010, 16'd3, 8'h11, 8'h22, 8'h33, 8'h00, 2, 1'b0, 1'b0, 8'h66);
        chk("sum_hold", {24'h0, bus.ld_sum}, 32'h66);
        read2(15'h0010, 15'h0011, 8'h11, 8'h22);
        read2(15'h0012, 15'h0012, 8'h33, 8'h33);

        // Pointer wraps from the top address to 0.
        load(15'h7FFF, 16'd2, 8'hAA, 8'h55, 8'h00, 8'h00, 1, 1'b0, 1'b0, 8'hFF);
        read2(15'h7FFF, 15'h0000, 8'hAA, 8'h55);

        // Read ports frozen during a load, then return the new data.
        read2(15'h0010, 15'h0011, 8'h11, 8'h22);
        load(15'h0010, 16'd2, 8'h77, 8'h88, 8'h00, 8'h00, 1, 1'b1, 1'b0, 8'hFF);
        exp_a = 8'h77;
        exp_b = 8'h88;
        tick();
        bus.rd_en = 1'b0;

        // clr after 2 of 4 words aborts without ld_done.
        bus.ld_base  = 15'h0020;
        bus.ld_len   = 16'd4;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'h5A;
        tick();
        bus.ld_data  = 8'h5B;
        tick();
        bus.ld_valid = 1'b0;
        clr          = 1'b1;
        tick();
        clr          = 1'b0;
        chk("abort_busy",  {31'h0, bus.ld_busy},  32'h0);
        chk("abort_ready", {31'h0, bus.ld_ready}, 32'h0);
        chk("abort_sum",   {24'h0, bus.ld_sum},   32'h0);
        read2(15'h0020, 15'h0021, 8'h5A, 8'h5B);
        read2(15'h0022, 15'h0023, 8'hC2, 8'hC3);

        // Zero-length load goes straight to DONE.
        done_q.push_back(8'h00);
        bus.ld_base  = 15'h0000;
        bus.ld_len   = 16'd0;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        chk("len0_done",  {31'h0, bus.ld_done},  32'h1);
        chk("len0_ready", {31'h0, bus.ld_ready}, 32'h0);
        chk("len0_busy",  {31'h0, bus.ld_busy},  32'h1);
        tick();
        chk("len0_idle",  {31'h0, bus.ld_busy},  32'h0);
        chk("len0_pulse", {31'h0, bus.ld_done},  32'h0);
        chk("len0_sum",   {24'h0, bus.ld_sum},   32'h0);
        read2(15'h0000, 15'h0000, 8'h55, 8'h55);

        // ld_start during a load is ignored.
        load(15'h0030, 16'd2, 8'h01, 8'h02, 8'h00, 8'h00, 0, 1'b0, 1'b1, 8'h03);
        read2(15'h0030, 15'h0031, 8'h01, 8'h02);

        tick();
        tick();
        tick();
        chk("rd_queue_drained",   rd_q.size(),   32'h0);
        chk("done_queue_drained", done_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
